// File: rtl/nes_pad_responder.sv
// ---------------------------------------------------------------------------
// nes_pad_responder
//
// Controller-side end of the NES serial pad protocol. It emulates a standard
// 4021-based pad. The host drives latch and pulse. This block presents the
// button state on the active-low serial data line, one bit per pulse edge.
//
// Ports:
//   clk         40 MHz system clock; all logic on posedge
//   reset       synchronous, active-high reset
//   latch       host latch line (asynchronous, active-high)
//   pulse       host pulse line (asynchronous); a rising edge advances one bit
//   buttons     parallel button state, 1 = pressed
//               (0=A 1=B 2=Select 3=Start 4=Up 5=Down 6=Left 7=Right)
//   data        serial data to host, active-low (0 = pressed)
//   frame_done  one-cycle strobe when the last shift of a frame completes
//   proto_err   one-cycle strobe on a pulse rise seen in IDLE or LOAD
//   bit_cnt     number of shifts completed in the current frame
// ---------------------------------------------------------------------------
module nes_pad_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_BITS    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        latch,
    input  logic                        pulse,
    input  logic [NUM_BITS-1:0]         buttons,
    output logic                        data,
    output logic                        frame_done,
    output logic                        proto_err,
    output logic [$clog2(NUM_BITS):0]   bit_cnt
);

    localparam int unsigned CW = $clog2(NUM_BITS) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] pulse_sync;
    logic                   latch_prev;
    logic                   pulse_prev;
    logic                   latch_s;
    logic                   pulse_s;
    logic                   latch_rise;
    logic                   latch_fall;
    logic                   pulse_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_sync <= '0;
            pulse_sync <= '0;
            latch_prev <= 1'b0;
            pulse_prev <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch};
            pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], pulse};
            latch_prev <= latch_s;
            pulse_prev <= pulse_s;
        end
    end

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign pulse_s    = pulse_sync[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_prev;
    assign latch_fall = ~latch_s & latch_prev;
    assign pulse_rise = pulse_s & ~pulse_prev;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    logic [1:0]          state;
    logic [1:0]          state_nx;
    logic [NUM_BITS-1:0] sr;
    logic [NUM_BITS-1:0] sr_nx;
    logic [CW-1:0]       cnt_nx;
    logic                fd_nx;
    logic                pe_nx;
    logic                data_nx;

    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = bit_cnt;
        fd_nx    = 1'b0;
        pe_nx    = 1'b0;

        if (latch_rise) begin
            // A new latch restarts the frame from any state. A pulse in the
            // same cycle is dropped and counts as an error only if the host
            // was already outside a frame.
            state_nx = ST_LOAD;
            sr_nx    = ~buttons;
            cnt_nx   = '0;
            pe_nx    = pulse_rise && (state == ST_IDLE || state == ST_LOAD);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pulse_rise)
                        pe_nx = 1'b1;
                end
                ST_LOAD: begin
                    cnt_nx = '0;
                    if (latch_fall) begin
                        // Keep the value from the last load cycle. A pulse
                        // coinciding with the fall is dropped silently.
                        state_nx = ST_SHIFT;
                    end else begin
                        sr_nx = ~buttons;
                        if (pulse_rise)
                            pe_nx = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (pulse_rise) begin
                        sr_nx  = {1'b0, sr[NUM_BITS-1:1]};
                        cnt_nx = bit_cnt + CW'(1);
                        if (cnt_nx == CNT_LAST) begin
                            state_nx = ST_DONE;
                            fd_nx    = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Extra reads return "pressed" (0) with the count saturated.
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end

        // data is registered, so derive it from the next-state values.
        case (state_nx)
            ST_IDLE: data_nx = 1'b1;
            ST_DONE: data_nx = 1'b0;
            default: data_nx = sr_nx[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sr         <= '1;
            bit_cnt    <= '0;
            data       <= 1'b1;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            sr         <= sr_nx;
            bit_cnt    <= cnt_nx;
            data       <= data_nx;
            frame_done <= fd_nx;
            proto_err  <= pe_nx;
        end
    end

endmodule

// File: tb/tb_nes_pad_responder.sv
module tb_nes_pad_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       latch = 1'b0;
    logic       pulse = 1'b0;
    logic [7:0] buttons = 8'h00;
    logic       data;
    logic       frame_done;
    logic       proto_err;
    logic [3:0] bit_cnt;

    int tests = 0;
    int fails = 0;
    int fd_cnt = 0;
    int pe_cnt = 0;
    int fd_base;
    int pe_base;
    logic [7:0] exp_bits;

    nes_pad_responder #(
        .SYNC_STAGES(2),
        .NUM_BITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .latch(latch),
        .pulse(pulse),
        .buttons(buttons),
        .data(data),
        .frame_done(frame_done),
        .proto_err(proto_err),
        .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    // Strobe counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (proto_err === 1'b1) pe_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_once(input int hi, input int lo);
        pulse = 1'b1;
        cyc(hi);
        pulse = 1'b0;
        cyc(lo);
    endtask

    initial begin
        // ---------------- Reset with latch high and pulse toggling
        reset = 1'b1;
        latch = 1'b1;
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            pulse = ~pulse;
            cyc(1);
            check("rst_data", 32'(data), 32'd1);
            check("rst_cnt", 32'(bit_cnt), 32'd0);
        end
        check("rst_fd", 32'(fd_cnt), 32'd0);
        check("rst_pe", 32'(pe_cnt), 32'd0);
        latch = 1'b0;
        pulse = 1'b0;
        reset = 1'b0;
        cyc(6);
        check("idle_data", 32'(data), 32'd1);

        // ---------------- Pulse in IDLE -> one proto_err
        pe_base = pe_cnt;
        pulse = 1'b1;
        cyc(2);
        check("idle_pe_early", 32'(proto_err), 32'd0);
        cyc(1);
        check("idle_pe_strobe", 32'(proto_err), 32'd1);
        cyc(5);
        check("idle_pe_cnt", 32'(pe_cnt - pe_base), 32'd1);
        check("idle_pe_bitcnt", 32'(bit_cnt), 32'd0);
        check("idle_pe_data", 32'(data), 32'd1);
        pulse = 1'b0;
        cyc(6);

        // ---------------- Nominal frame, A+Select+Right
        buttons = 8'b1000_0101;
        exp_bits = 8'b0111_1010;
        fd_base = fd_cnt;
        pe_base = pe_cnt;
        latch = 1'b1;
        cyc(480);
        check("nom_load_data", 32'(data), 32'd0);
        check("nom_load_cnt", 32'(bit_cnt), 32'd0);
        latch = 1'b0;
        cyc(240);
        for (int i = 0; i < 8; i++) begin
            check("nom_bit", 32'(data), 32'(exp_bits[i]));
            check("nom_cnt", 32'(bit_cnt), 32'(i));
            if (i < 7) begin
                pulse_once(240, 240);
            end else begin
                pulse = 1'b1;
                cyc(2);
                check("nom_fd_early", 32'(frame_done), 32'd0);
                cyc(1);
                check("nom_fd_strobe", 32'(frame_done), 32'd1);
                check("nom_cnt8", 32'(bit_cnt), 32'd8);
                check("nom_data_done", 32'(data), 32'd0);
                cyc(1);
                check("nom_fd_clear", 32'(frame_done), 32'd0);
                cyc(236);
                pulse = 1'b0;
                cyc(240);
            end
        end
        check("nom_fd_cnt", 32'(fd_cnt - fd_base), 32'd1);
        check("nom_pe_cnt", 32'(pe_cnt - pe_base), 32'd0);

        // ---------------- Transparent load
        buttons = 8'h00;
        latch = 1'b1;
        cyc(6);
        check("tl_data_00", 32'(data), 32'd1);
        buttons = 8'h01;
        cyc(1);
        check("tl_data_01", 32'(data), 32'd0);
        buttons = 8'h00;
        cyc(1);
        check("tl_data_back", 32'(data), 32'd1);
        buttons = 8'h01;
        cyc(4);
        latch = 1'b0;
        cyc(6);
        buttons = 8'h00;
        cyc(4);
        check("tl_frozen", 32'(data), 32'd0);
        buttons = 8'hFE;
        cyc(4);
        check("tl_frozen2", 32'(data), 32'd0);
        check("tl_cnt", 32'(bit_cnt), 32'd0);

        // ---------------- Extra reads: 12 pulses
        buttons = 8'h5A;
        exp_bits = 8'hA5;
        fd_base = fd_cnt;
        pe_base = pe_cnt;
        latch = 1'b1;
        cyc(10);
        latch = 1'b0;
        cyc(10);
        for (int k = 1; k <= 12; k++) begin
            if (k <= 8)
                check("xr_bit", 32'(data), 32'(exp_bits[k-1]));
            else
                check("xr_extra_data", 32'(data), 32'd0);
            pulse_once(8, 8);
            check("xr_cnt", 32'(bit_cnt), (k < 8) ? 32'(k) : 32'd8);
        end
        check("xr_pe_cnt", 32'(pe_cnt - pe_base), 32'd0);
        check("xr_fd_cnt", 32'(fd_cnt - fd_base), 32'd1);

        // ---------------- Abort a partial frame
        buttons = 8'hFF;
        fd_base = fd_cnt;
        latch = 1'b1;
        cyc(10);
        latch = 1'b0;
        cyc(10);
        check("ab_data0", 32'(data), 32'd0);
        for (int i = 0; i < 3; i++) pulse_once(8, 8);
        check("ab_cnt3", 32'(bit_cnt), 32'd3);
        buttons = 8'h00;
        latch = 1'b1;
        cyc(4);
        check("ab_cnt_clr", 32'(bit_cnt), 32'd0);
        check("ab_data1", 32'(data), 32'd1);
        check("ab_no_fd", 32'(fd_cnt - fd_base), 32'd0);
        cyc(6);
        latch = 1'b0;
        cyc(10);
        for (int i = 0; i < 8; i++) begin
            check("ab_bit", 32'(data), 32'd1);
            pulse_once(8, 8);
        end
        check("ab_cnt8", 32'(bit_cnt), 32'd8);
        check("ab_done_data", 32'(data), 32'd0);
        check("ab_fd_cnt", 32'(fd_cnt - fd_base), 32'd1);

        // ---------------- Pulse while latch high
        buttons = 8'h01;
        latch = 1'b1;
        cyc(10);
        pe_base = pe_cnt;
        check("pe_load_data", 32'(data), 32'd0);
        pulse = 1'b1;
        cyc(8);
        check("pe_load_cnt1", 32'(pe_cnt - pe_base), 32'd1);
        check("pe_load_bitcnt", 32'(bit_cnt), 32'd0);
        check("pe_load_data2", 32'(data), 32'd0);
        pulse = 1'b0;
        cyc(8);
        check("pe_load_cnt_hold", 32'(pe_cnt - pe_base), 32'd1);

        // ---------------- Latch fall together with pulse rise
        buttons = 8'h02;
        cyc(4);
        check("lf_data_pre", 32'(data), 32'd1);
        pe_base = pe_cnt;
        latch = 1'b0;
        pulse = 1'b1;
        cyc(8);
        check("lf_no_shift", 32'(bit_cnt), 32'd0);
        check("lf_no_pe", 32'(pe_cnt - pe_base), 32'd0);
        check("lf_data", 32'(data), 32'd1);
        pulse = 1'b0;
        cyc(8);
        pulse_once(8, 8);
        check("lf_shift1_cnt", 32'(bit_cnt), 32'd1);
        check("lf_shift1_data", 32'(data), 32'd0);

        // ---------------- Reset mid-frame
        latch = 1'b1;
        reset = 1'b1;
        cyc(1);
        check("mr_cnt", 32'(bit_cnt), 32'd0);
        check("mr_data", 32'(data), 32'd1);
        reset = 1'b0;
        latch = 1'b0;
        cyc(6);
        check("mr_idle_data", 32'(data), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
